// File: rtl/udc_pkg.sv
// Shared definitions for the UDC command scheduler: command opcodes,
// FSM state encoding and the width of the shared up/down counter.
package udc_pkg;

  localparam int CTR_W = 4;

  // Command opcodes as presented on reqN_op.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/udc_rr_arb.sv
// Two-requester round-robin arbiter. The grant is combinational.
// The pointer records the last requester granted and moves only when the
// grant is accepted.
module udc_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q;  // index of the requester granted most recently

  // Grant the lone requester, or the one not served last when both ask.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Pointer update on an accepted grant; reset favours req0.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/udc_cmd_scheduler.sv
// Command scheduler for a shared 4-bit up/down counter. Two requesters are
// served round-robin, with one command in flight at a time. The command
// is turned into counter control pulses, and a registered done pulse
// marks its completion.
// Optional build macro: UDC_SAT_EN. When it is defined, UP/DOWN commands
// stop early at 15/0 and report done_sat.
module udc_cmd_scheduler
  import udc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [CTR_W-1:0] req0_arg,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [CTR_W-1:0] req1_arg,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             ctr_reset,
  output logic             ctr_load,
  output logic             ctr_up,
  output logic             ctr_down,
  output logic [CTR_W-1:0] ctr_data,
  input  logic [CTR_W-1:0] ctr_count,
  output logic             done,
  output logic             done_id,
  output logic             done_sat,
  output logic             busy
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CTR_W-1:0] arg_q;
  logic             id_q;
  logic [CTR_W-1:0] step_q, step_d;
  logic             done_q, done_id_q, done_sat_q;

  logic             in_idle;
  logic [1:0]       grant;
  logic             handshake;
  logic [1:0]       sel_op;
  logic [CTR_W-1:0] sel_arg;
  logic             at_limit;
  logic             finish_sat;
  logic             enter_done;

  assign in_idle = (state_q == IDLE);

  // Requests reach the arbiter only in IDLE, so ready never leaks out of it.
  udc_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid} & {2{in_idle}}),
    .accept  (in_idle),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign handshake  = grant[0] | grant[1];
  assign sel_op     = grant[1] ? req1_op  : req0_op;
  assign sel_arg    = grant[1] ? req1_arg : req0_arg;

`ifdef UDC_SAT_EN
  // A step that would wrap the counter is withheld instead.
  assign at_limit = (op_q == OP_UP) ? (ctr_count == {CTR_W{1'b1}})
                                    : (ctr_count == {CTR_W{1'b0}});
`else
  // The counter is allowed to wrap, so its value does not matter here.
  logic unused_count;
  assign unused_count = ^ctr_count;
  assign at_limit     = 1'b0;
`endif

  // Next state and counter controls. The controls are active only in RUN.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ctr_reset  = 1'b0;
    ctr_load   = 1'b0;
    ctr_up     = 1'b0;
    ctr_down   = 1'b0;
    ctr_data   = '0;
    finish_sat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = RUN;
          step_d  = sel_arg;
        end
      end
      RUN: begin
        unique case (op_q)
          OP_LOAD: begin
            ctr_load = 1'b1;
            ctr_data = arg_q;
            state_d  = DONE;
          end
          OP_CLEAR: begin
            ctr_reset = 1'b1;
            state_d   = DONE;
          end
          default: begin
            // UP/DOWN: one step per cycle until the step count runs out.
            if (step_q == '0) begin
              state_d = DONE;
            end else if (at_limit) begin
              finish_sat = 1'b1;
              step_d     = '0;
              state_d    = DONE;
            end else begin
              ctr_up   = (op_q == OP_UP);
              ctr_down = (op_q == OP_DOWN);
              step_d   = step_q - 1'b1;
              if (step_q == {{(CTR_W-1){1'b0}}, 1'b1}) begin
                state_d = DONE;
              end
            end
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_q == RUN) && (state_d == DONE);

  // FSM state, step counter and the registered completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      done_sat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      done_q     <= enter_done;
      done_id_q  <= enter_done & id_q;
      done_sat_q <= enter_done & finish_sat;
    end
  end

  // Capture the accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= OP_LOAD;
      arg_q <= '0;
      id_q  <= 1'b0;
    end else if (handshake) begin
      op_q  <= op_e'(sel_op);
      arg_q <= sel_arg;
      id_q  <= grant[1];
    end
  end

  assign done     = done_q;
  assign done_id  = done_id_q;
  assign done_sat = done_sat_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_udc_cmd_scheduler.sv
// Directed bench for udc_cmd_scheduler. A behavioural 4-bit up/down counter
// acts as the load. Each accepted command pushes its expected completion
// (id, saturation flag, cycle, final count, control pulses) to a scoreboard.
// Each done pulse pops one entry and compares it.
module tb_udc_cmd_scheduler;
  import udc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
  logic [3:0] req0_arg = 4'd0, req1_arg = 4'd0;
  logic       req0_ready, req1_ready;
  logic       ctr_reset, ctr_load, ctr_up, ctr_down;
  logic [3:0] ctr_data, ctr_count;
  logic       done, done_id, done_sat, busy;

  udc_cmd_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_arg(req0_arg),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_arg(req1_arg),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .ctr_reset(ctr_reset), .ctr_load(ctr_load), .ctr_up(ctr_up), .ctr_down(ctr_down),
    .ctr_data(ctr_data), .ctr_count(ctr_count),
    .done(done), .done_id(done_id), .done_sat(done_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared counter load. reset_n does not clear it.
  logic [3:0] cnt = 4'd0;
  always @(posedge clk) begin
    if (ctr_reset)     cnt <= 4'd0;
    else if (ctr_load) cnt <= ctr_data;
    else if (ctr_up)   cnt <= cnt + 4'd1;
    else if (ctr_down) cnt <= cnt - 4'd1;
  end
  assign ctr_count = cnt;

  // Cycle monitor: counts control pulses and flags protocol violations.
  int pulses = 0;
  bit multi_ctl = 0, dual_ready = 0, bad_data = 0, ctl_outside = 0;
  always @(negedge clk) begin
    int n;
    n = int'(ctr_reset) + int'(ctr_load) + int'(ctr_up) + int'(ctr_down);
    pulses <= pulses + n;
    if (n > 1) multi_ctl <= 1'b1;
    if (req0_ready && req1_ready) dual_ready <= 1'b1;
    if (!ctr_load && ctr_data != 4'd0) bad_data <= 1'b1;
    if (!busy && n != 0) ctl_outside <= 1'b1;
  end

  typedef struct {
    bit         id;
    bit         sat;
    logic [3:0] count;
    int         cyc;
    int         npulse;
    int         base;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_count = 4'd0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Work out the expected completion of a command accepted in cycle k.
  task automatic expect_cmd(input bit id, input logic [1:0] op, input logic [3:0] arg, input int k);
    exp_t       e;
    int         run;
    logic [3:0] c;
    c        = exp_count;
    e.id     = id;
    e.sat    = 1'b0;
    e.npulse = 0;
    run      = 1;
    case (op)
      OP_LOAD:  begin c = arg;  e.npulse = 1; end
      OP_CLEAR: begin c = 4'd0; e.npulse = 1; end
      default: begin
        for (int i = 0; i < int'(arg); i++) begin
`ifdef UDC_SAT_EN
          if ((op == OP_UP && c == 4'hf) || (op == OP_DOWN && c == 4'h0)) begin
            e.sat = 1'b1;
            break;
          end
`endif
          c = (op == OP_UP) ? c + 4'd1 : c - 4'd1;
          e.npulse++;
        end
        if (e.sat)          run = e.npulse + 1;
        else if (arg == 0)  run = 1;
        else                run = int'(arg);
      end
    endcase
    e.count   = c;
    e.cyc     = k + 1 + run;
    e.base    = pulses;
    exp_count = c;
    sb.push_back(e);
  endtask

  // Wait (bounded) for ready on one requester. Call shortly after a negedge.
  task automatic wait_ready(input bit id, output int k);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      #1;
      if (id ? req1_ready : req0_ready) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("ready_seen", got, 1);
    k = cyc;
  endtask

  // Wait (bounded) for any ready, reporting which requester was granted.
  task automatic wait_any(output bit gid, output int k);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      #1;
      if (req0_ready || req1_ready) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("any_ready_seen", got, 1);
    gid = req1_ready;
    k   = cyc;
  endtask

  // Wait (bounded) for done, then compare it against the scoreboard head.
  task automatic wait_done();
    exp_t e;
    int   n;
    bit   got;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk); #1; n++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        chk("done_id", done_id, e.id);
        chk("done_sat", done_sat, e.sat);
        chk("done_cycle", cyc, e.cyc);
        chk("final_count", ctr_count, e.count);
        chk("ctl_pulses", pulses - e.base, e.npulse);
        @(negedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
      end
    end
  endtask

  // Single-requester command: present it, handshake, release, await done.
  task automatic issue(input bit id, input logic [1:0] op, input logic [3:0] arg);
    int k;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_arg = arg; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_arg = arg; end
    wait_ready(id, k);
    expect_cmd(id, op, arg, k);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    bit gid;
    int k;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_ctl", {ctr_reset, ctr_load, ctr_up, ctr_down}, 0);
    chk("rst_done", {done, done_id, done_sat}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // LOAD 2 from req0, then UP 3 from req1.
    issue(1'b0, OP_LOAD, 4'd2);
    issue(1'b1, OP_UP, 4'd3);

    // Both requesters hold DOWN 1; grants must alternate 0,1,0,1.
    req0_valid = 1'b1; req0_op = OP_DOWN; req0_arg = 4'd1;
    req1_valid = 1'b1; req1_op = OP_DOWN; req1_arg = 4'd1;
    for (int i = 0; i < 4; i++) begin
      wait_any(gid, k);
      chk("rr_grant", gid, i % 2);
      expect_cmd(gid, OP_DOWN, 4'd1, k);
      wait_done();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Saturation boundary: count 14, UP 4.
    issue(1'b0, OP_LOAD, 4'd14);
    issue(1'b1, OP_UP, 4'd4);

    // CLEAR from 9, then UP with zero steps.
    issue(1'b0, OP_LOAD, 4'd9);
    issue(1'b1, OP_CLEAR, 4'd5);
    issue(1'b0, OP_UP, 4'd0);
    issue(1'b1, OP_DOWN, 4'd2);

    // Reset during UP 8 from req0 after three steps have landed.
    issue(1'b1, OP_LOAD, 4'd1);
    req0_valid = 1'b1; req0_op = OP_UP; req0_arg = 4'd8;
    wait_ready(1'b0, k);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ctl", {ctr_reset, ctr_load, ctr_up, ctr_down}, 0);
    chk("abort_done", {done, done_id, done_sat}, 0);
    chk("abort_count", ctr_count, 4'd4);
    exp_count = 4'd4;
    repeat (2) begin
      @(negedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    reset_n = 1'b1;

    // After reset the pointer favours req0 again.
    req0_valid = 1'b1; req0_op = OP_LOAD; req0_arg = 4'd7;
    req1_valid = 1'b1; req1_op = OP_LOAD; req1_arg = 4'd3;
    wait_any(gid, k);
    chk("post_reset_grant", gid, 0);
    expect_cmd(gid, OP_LOAD, 4'd7, k);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done();

    // Properties accumulated by the cycle monitor.
    chk("ctl_one_hot", multi_ctl, 0);
    chk("ready_exclusive", dual_ready, 0);
    chk("data_zero_unless_load", bad_data, 0);
    chk("ctl_only_in_run", ctl_outside, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udc_cmd_scheduler.md
UDC_CMD_SCHEDULER -- requirements
Module: udc_cmd_scheduler

Interface
REQ-001 SHALL: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: req0_valid / req1_valid  input  1  requester i holds a command.
REQ-004 SHALL: req0_op / req1_op  input  2  command: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-005 SHALL: req0_arg / req1_arg  input  4  LOAD value, or UP/DOWN step count; ignored for CLEAR.
REQ-006 SHALL: req0_ready / req1_ready  output  1  command accepted this cycle (valid && ready).
REQ-007 SHALL: ctr_reset, ctr_load, ctr_up, ctr_down  output  1 each  drive the shared 4-bit up/down counter.
REQ-008 SHALL: ctr_data  output  4  counter data_in.
REQ-009 SHALL: ctr_count  input  4  counter's current count.
REQ-010 SHALL: done  output  1  one-cycle completion pulse.
REQ-011 SHALL: done_id  output  1  requester of the completed command; valid with done.
REQ-012 SHALL: done_sat  output  1  command ended early on saturation; valid with done.
REQ-013 SHALL: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL: FSM states IDLE, RUN, DONE; exactly one command in flight.
REQ-015 SHALL: in IDLE, if any valid, assert ready to exactly one requester combinationally; on handshake latch op, arg and id, go to RUN.
REQ-016 SHALL: arbitration is round-robin: both valid -> grant the requester not granted last; one valid -> grant it; pointer updates only on handshake.
REQ-017 SHALL: requesters hold valid/op/arg stable until ready; ready never asserts outside IDLE.
REQ-018 SHALL: LOAD: ctr_load=1 and ctr_data=arg for exactly one RUN cycle, then DONE.
REQ-019 SHALL: CLEAR: ctr_reset=1 for exactly one RUN cycle, then DONE.
REQ-020 SHALL: UP/DOWN with arg=N>0: ctr_up (ctr_down) high for exactly N consecutive RUN cycles via internal 4-bit step counter, then DONE.
REQ-021 SHALL: UP/DOWN with arg=0: one RUN cycle with no control asserted, then DONE.
REQ-022 SHALL: at most one of ctr_reset/ctr_load/ctr_up/ctr_down high in any cycle; all low outside RUN; ctr_data=0 when ctr_load low.
REQ-023 SHALL: latency: handshake cycle T, first control cycle T+1, done at T+1+max(N,1) for UP/DOWN, T+2 for LOAD/CLEAR.
REQ-024 SHALL: DONE lasts one cycle (done=1, done_id, done_sat), then IDLE; next handshake earliest one cycle after done.
REQ-025 SHALL: done, done_id, done_sat are registered (no combinational path from inputs).

Reset
REQ-026 SHALL: reset_n low immediately forces IDLE, all ctr_* = 0, ready=0, done=0, done_id=0, done_sat=0, busy=0, step counter=0, arbitration pointer favouring req0.
REQ-027 SHALL: reset mid-RUN aborts the command with no done pulse; counter value is left as is.

Configuration
REQ-028 SHALL: macro UDC_SAT_EN defined -> before each UP (DOWN) step, if ctr_count==15 (0) the step is not issued, RUN ends, DONE with done_sat=1.
REQ-029 SHALL: UDC_SAT_EN undefined -> all N steps issued regardless of ctr_count (counter wraps), done_sat tied 0.

Structure
REQ-030 SHALL: shared package udc_pkg holds op encoding constants (OP_LOAD, OP_UP, OP_DOWN, OP_CLEAR), FSM state encoding, counter width 4.
REQ-031 SHALL: round-robin grant logic is sub-module udc_rr_arb (2 requests, pointer, grant, accept input).
REQ-032 SHALL: target size 120-400 RTL lines; bench instantiates the up_down_counter as the load.

Verification
REQ-033 SHALL: reset_n low 2 cycles, req0 LOAD arg=2 -> ready0 at T, ctr_load with ctr_data=2 at T+1, done at T+2 done_id=0, count=2.
REQ-034 SHALL: from count 2, req1 UP arg=3 -> ctr_up high 3 cycles, count=5, done at T+4 done_id=1.
REQ-035 SHALL: both valid continuously, req0 then req1 DOWN arg=1 -> grants alternate 0,1,0,1; never two ready in one cycle.
REQ-036 SHALL: count=14, UP arg=4 -> with UDC_SAT_EN: 1 step, count=15, done_sat=1; without: 4 steps, count=2, done_sat=0.
REQ-037 SHALL: reset_n low during UP arg=8 after 3 steps -> all outputs 0 immediately, no done, next grant goes to req0.
REQ-038 SHALL: CLEAR from count=9 -> ctr_reset one cycle, count=0; UP arg=0 -> no step, done at T+2.
